// File: rtl/if_stage_pkg.sv
// Shared sizes, state encodings and byte-count constants for the instruction-fetch stage.
package if_stage_pkg;

  localparam int INSTRUCTION_ADDRESS_SIZE = 32;
  localparam int INSTRUCTION_SIZE         = 32;
  localparam int STALL_SIZE               = 6;
  localparam int BYTE_CNT_W               = 3;
  localparam int IF_STALL_BIT             = 0;

  localparam logic [BYTE_CNT_W-1:0] BYTES_PER_INSTR = 3'd4;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE       = 3'd3;

  typedef enum logic {
    IF_FETCH = 1'b0,
    IF_HOLD  = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_byte_assembler.sv
// Collects returned bytes little-endian into a 32-bit word; discards the one byte
// still in flight when a redirect lands, and pulses done on the fourth capture.
module if_byte_assembler
  import if_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        clear_i,
  input  logic                        pend_i,
  input  logic                        rvalid_i,
  input  logic [7:0]                  rdata_i,
  output logic [INSTRUCTION_SIZE-1:0] word_o,
  output logic                        done_o
);

  logic [BYTE_CNT_W-1:0]       recv_cnt_q, recv_cnt_d;
  logic                        drop_q, drop_d;
  logic [INSTRUCTION_SIZE-1:0] word_q, word_d;
  logic                        capture;

  assign capture = rvalid_i && pend_i && !drop_q && !flush_i;
  assign done_o  = capture && (recv_cnt_q == LAST_BYTE);
  assign word_o  = word_q;

  always_comb begin
    recv_cnt_d = recv_cnt_q;
    drop_d     = drop_q;
    word_d     = word_q;
    if (flush_i) begin
      recv_cnt_d = '0;
      word_d     = '0;
      // A byte arriving in the redirect cycle is simply not captured; only a
      // byte still outstanding afterwards needs to be swallowed later.
      drop_d     = pend_i && !rvalid_i;
    end else begin
      if (rvalid_i && drop_q) begin
        drop_d = 1'b0;
      end
      if (clear_i) begin
        recv_cnt_d = '0;
        word_d     = '0;
      end else if (capture) begin
        word_d[{recv_cnt_q[1:0], 3'b000} +: 8] = rdata_i;
        recv_cnt_d = recv_cnt_q + BYTE_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      recv_cnt_q <= '0;
      drop_q     <= 1'b0;
      word_q     <= '0;
    end else begin
      recv_cnt_q <= recv_cnt_d;
      drop_q     <= drop_d;
      word_q     <= word_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues four byte reads per instruction,
// presents the assembled word to IF/ID and picks the next PC from predictor or EX redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                ADDR_W   = INSTRUCTION_ADDRESS_SIZE,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [STALL_SIZE-1:0]       stall_state,
  input  logic                        jump_flag,
  input  logic [ADDR_W-1:0]           jump_target,
  input  logic                        pred_taken,
  input  logic [ADDR_W-1:0]           pred_target,
  output logic [ADDR_W-1:0]           pc_o,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_grant,
  input  logic                        mem_rvalid,
  input  logic [7:0]                  mem_rdata,
  output logic                        if_stall_req,
  output logic [ADDR_W-1:0]           pc,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic                        prediction
);

  if_state_e                   state_q, state_d;
  logic [ADDR_W-1:0]           pc_fetch_q, pc_fetch_d;
  logic [ADDR_W-1:0]           pc_out_q, pc_out_d;
  logic [BYTE_CNT_W-1:0]       issue_cnt_q, issue_cnt_d;
  logic                        pend_q, pend_d;
  logic                        pred_q, pred_d;
  logic                        fire, release_hold, asm_done;
  logic [INSTRUCTION_SIZE-1:0] asm_word;
  logic                        unused_stall_bits;

  assign unused_stall_bits = ^stall_state[STALL_SIZE-1:1];

  // One byte in flight at most: a new request may only go out once the previous byte is back.
  assign mem_req = rst && (state_q == IF_FETCH) && (issue_cnt_q < BYTES_PER_INSTR)
                   && (!pend_q || mem_rvalid) && !jump_flag;
  assign mem_addr     = pc_fetch_q + ADDR_W'(issue_cnt_q);
  assign fire         = mem_req && mem_grant;
  assign release_hold = (state_q == IF_HOLD) && !stall_state[IF_STALL_BIT] && !jump_flag;

  if_byte_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (jump_flag),
    .clear_i  (release_hold),
    .pend_i   (pend_q),
    .rvalid_i (mem_rvalid),
    .rdata_i  (mem_rdata),
    .word_o   (asm_word),
    .done_o   (asm_done)
  );

  always_comb begin
    state_d     = state_q;
    pc_fetch_d  = pc_fetch_q;
    pc_out_d    = pc_out_q;
    issue_cnt_d = issue_cnt_q;
    pred_d      = pred_q;
    pend_d      = pend_q;
    if (fire) begin
      pend_d = 1'b1;
    end else if (mem_rvalid) begin
      pend_d = 1'b0;
    end
    if (jump_flag) begin
      pc_fetch_d  = jump_target;
      issue_cnt_d = '0;
      state_d     = IF_FETCH;
    end else begin
      case (state_q)
        IF_FETCH: begin
          if (fire) begin
            issue_cnt_d = issue_cnt_q + BYTE_CNT_W'(1);
          end
          if (asm_done) begin
            pc_out_d = pc_fetch_q;
            pred_d   = pred_taken;
            state_d  = IF_HOLD;
          end
        end
        IF_HOLD: begin
          if (release_hold) begin
            pc_fetch_d  = pred_taken ? pred_target : pc_fetch_q + ADDR_W'(4);
            issue_cnt_d = '0;
            state_d     = IF_FETCH;
          end
        end
        default: state_d = IF_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IF_FETCH;
      pc_fetch_q  <= RESET_PC;
      pc_out_q    <= '0;
      issue_cnt_q <= '0;
      pend_q      <= 1'b0;
      pred_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_fetch_q  <= pc_fetch_d;
      pc_out_q    <= pc_out_d;
      issue_cnt_q <= issue_cnt_d;
      pend_q      <= pend_d;
      pred_q      <= pred_d;
    end
  end

  assign pc_o         = pc_fetch_q;
  assign if_stall_req = (state_q != IF_HOLD);
  assign pc           = (state_q == IF_HOLD) ? pc_out_q : '0;
  assign instruction  = (state_q == IF_HOLD) ? asm_word : '0;
  assign prediction   = (state_q == IF_HOLD) && pred_q;

endmodule
